// File: rtl/imm_field_encoder_pkg.sv
// Shared definitions for the immediate-field encoder: format codes, field
// bit positions, FSM state type and wide-beat helpers.
package imm_field_encoder_pkg;

    localparam logic [2:0] FMT_I        = 3'b000;
    localparam logic [2:0] FMT_D        = 3'b001;
    localparam logic [2:0] FMT_B        = 3'b010;
    localparam logic [2:0] FMT_CB       = 3'b011;
    localparam int unsigned FMT_WIDE_MSB = 2;

    localparam int unsigned I_LSB        = 10;
    localparam int unsigned D_LSB        = 12;
    localparam int unsigned CB_LSB       = 5;
    localparam int unsigned WIDE_IMM_LSB = 5;
    localparam int unsigned WIDE_HW_LSB  = 21;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    function automatic logic [1:0] lowest_hw(input logic [3:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    function automatic logic [25:0] wide_field(input logic [63:0] value, input logic [1:0] hw);
        logic [15:0] half;
        case (hw)
            2'd0:    half = value[15:0];
            2'd1:    half = value[31:16];
            2'd2:    half = value[47:32];
            default: half = value[63:48];
        endcase
        return (26'(hw) << WIDE_HW_LSB) | (26'(half) << WIDE_IMM_LSB);
    endfunction

endpackage

// File: rtl/imm_field_encoder_if.sv
// Request/beat handshake bundle for the immediate-field encoder.
// slave = encoder side, master = requester/consumer side.
interface imm_field_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ctrl;
    logic [63:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_imm26;
    logic        out_movk;
    logic        out_last;
    logic        out_err;

    modport slave (
        input  in_valid, in_ctrl, in_value, out_ready,
        output in_ready, out_valid, out_imm26, out_movk, out_last, out_err
    );

    modport master (
        output in_valid, in_ctrl, in_value, out_ready,
        input  in_ready, out_valid, out_imm26, out_movk, out_last, out_err
    );

endinterface

// File: rtl/imm_range_check.sv
// Combinational legality check and field packing for single-beat formats.
// Illegal values yield imm26=0 so the caller never sees a truncated field.
module imm_range_check
    import imm_field_encoder_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [63:0] value,
    output logic        legal,
    output logic [25:0] imm26
);

    logic [25:0] packed_imm;

    always_comb begin
        legal      = 1'b0;
        packed_imm = '0;
        if (ctrl[FMT_WIDE_MSB]) begin
            legal = 1'b1;
        end else begin
            case (ctrl)
                FMT_I: begin
                    legal      = (value[63:12] == '0);
                    packed_imm = 26'(value[11:0]) << I_LSB;
                end
                FMT_D: begin
                    legal      = (value[63:8] == '0) || (value[63:8] == '1);
                    packed_imm = 26'(value[8:0]) << D_LSB;
                end
                FMT_B: begin
                    legal      = (value[63:25] == '0) || (value[63:25] == '1);
                    packed_imm = value[25:0];
                end
                FMT_CB: begin
                    legal      = (value[63:18] == '0) || (value[63:18] == '1);
                    packed_imm = 26'(value[18:0]) << CB_LSB;
                end
                default: begin
                    legal      = 1'b0;
                    packed_imm = '0;
                end
            endcase
        end
        imm26 = legal ? packed_imm : '0;
    end

endmodule

// File: rtl/imm_field_encoder.sv
// Encodes a 64-bit constant into instruction immediate field beats:
// one beat for I/D/B/CB, a MOVZ/MOVK sequence for wide constants.
module imm_field_encoder
    import imm_field_encoder_pkg::*;
#(
    parameter bit WIDE_SKIP_ZERO = 1'b1
) (
    input  logic               CLK,
    input  logic               Reset_L,
    imm_field_encoder_if.slave bus
);

    state_t      state_q, state_d;
    logic [63:0] value_q;
    logic [3:0]  pend_q;
    logic [25:0] imm_q;
    logic        movk_q, last_q, err_q;

    logic        chk_legal;
    logic [25:0] chk_imm;
    logic        accept, beat_done;
    logic [3:0]  mask_acc, pend_first, pend_next;
    logic [1:0]  hw_first, hw_next;

    imm_range_check u_range_check (
        .ctrl  (bus.in_ctrl),
        .value (bus.in_value),
        .legal (chk_legal),
        .imm26 (chk_imm)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_imm26 = imm_q;
    assign bus.out_movk  = movk_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign beat_done = bus.out_valid && bus.out_ready;

    // pend_* tracks halfwords still owed after the beat being presented
    always_comb begin
        mask_acc = '1;
        if (WIDE_SKIP_ZERO) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mask_acc[i] = (bus.in_value[16*i +: 16] != '0);
            end
            if (mask_acc == '0) begin
                mask_acc = 4'b0001;
            end
        end
        hw_first   = lowest_hw(mask_acc);
        pend_first = mask_acc & ~(4'b0001 << hw_first);
        hw_next    = lowest_hw(pend_q);
        pend_next  = pend_q & ~(4'b0001 << hw_next);
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EMIT;
            EMIT:    if (beat_done && last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            value_q <= '0;
            pend_q  <= '0;
            imm_q   <= '0;
            movk_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            value_q <= bus.in_value;
            if (bus.in_ctrl[FMT_WIDE_MSB]) begin
                imm_q  <= wide_field(bus.in_value, hw_first);
                movk_q <= 1'b0;
                last_q <= (pend_first == '0);
                err_q  <= 1'b0;
                pend_q <= pend_first;
            end else begin
                imm_q  <= chk_imm;
                movk_q <= 1'b0;
                last_q <= 1'b1;
                err_q  <= !chk_legal;
                pend_q <= '0;
            end
        end else if (beat_done && !last_q) begin
            imm_q  <= wide_field(value_q, hw_next);
            movk_q <= 1'b1;
            last_q <= (pend_next == '0);
            pend_q <= pend_next;
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed self-checking bench for imm_field_encoder (skip-zero and
// all-halfword instances sharing one clock and reset).
module tb_imm_field_encoder;
    import imm_field_encoder_pkg::*;

    logic CLK = 1'b0;
    logic Reset_L;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    imm_field_encoder_if bus ();
    imm_field_encoder_if bus_ns ();

    imm_field_encoder #(.WIDE_SKIP_ZERO(1'b1)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus.slave)
    );

    imm_field_encoder #(.WIDE_SKIP_ZERO(1'b0)) dut_ns (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus_ns.slave)
    );

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [63:0] value;
        logic [25:0] imm;
        logic        err;
    } vec_t;

    // Returns at the falling edge after acceptance; inputs then scrambled.
    task automatic send(input logic [2:0] c, input logic [63:0] v);
        @(negedge CLK);
        bus.in_valid = 1'b1;
        bus.in_ctrl  = c;
        bus.in_value = v;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        bus.in_ctrl  = 3'b010;
        bus.in_value = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic send_ns(input logic [2:0] c, input logic [63:0] v);
        @(negedge CLK);
        bus_ns.in_valid = 1'b1;
        bus_ns.in_ctrl  = c;
        bus_ns.in_value = v;
        @(negedge CLK);
        bus_ns.in_valid = 1'b0;
        bus_ns.in_ctrl  = 3'b001;
        bus_ns.in_value = 64'hFFFF_0000_FFFF_0000;
    endtask

    task automatic test_reset();
        logic [30:0] got;
        Reset_L = 1'b0;
        #1;
        got = {1'b0, bus.out_valid, bus.out_imm26, bus.out_movk, bus.out_last, bus.out_err};
        n_checks++;
        if (got !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", got, 31'd0);
        end
        @(negedge CLK);
        Reset_L = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required %b", {bus.in_ready, bus.out_valid}, 2'b10);
        end
    endtask

    task automatic test_single();
        vec_t vq[$];
        logic [30:0] got, exp;
        vq.push_back('{"i_0x123",     FMT_I,  64'h123,                 26'h0048C00, 1'b0});
        vq.push_back('{"i_4096",      FMT_I,  64'd4096,                26'h0,       1'b1});
        vq.push_back('{"i_4095",      FMT_I,  64'd4095,                26'h03FFC00, 1'b0});
        vq.push_back('{"d_neg4",      FMT_D,  64'hFFFF_FFFF_FFFF_FFFC, 26'h01FC000, 1'b0});
        vq.push_back('{"d_256",       FMT_D,  64'd256,                 26'h0,       1'b1});
        vq.push_back('{"d_neg256",    FMT_D,  64'hFFFF_FFFF_FFFF_FF00, 26'h0100000, 1'b0});
        vq.push_back('{"cb_neg2p18",  FMT_CB, 64'hFFFF_FFFF_FFFC_0000, 26'h0800000, 1'b0});
        vq.push_back('{"cb_2p18",     FMT_CB, 64'h0000_0000_0004_0000, 26'h0,       1'b1});
        vq.push_back('{"b_max",       FMT_B,  64'h0000_0000_01FF_FFFF, 26'h1FFFFFF, 1'b0});
        vq.push_back('{"b_2p25",      FMT_B,  64'h0000_0000_0200_0000, 26'h0,       1'b1});
        bus.out_ready = 1'b1;
        foreach (vq[k]) begin
            send(vq[k].ctrl, vq[k].value);
            exp = {1'b0, 1'b1, vq[k].imm, 1'b0, 1'b1, vq[k].err};
            got = {bus.in_ready, bus.out_valid, bus.out_imm26, bus.out_movk, bus.out_last, bus.out_err};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", vq[k].name, got, exp);
            end
            @(negedge CLK);
            n_checks++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL %s_done: got %b required %b", vq[k].name, {bus.in_ready, bus.out_valid}, 2'b10);
            end
        end
    endtask

    task automatic test_wide_skip();
        logic [29:0] got;
        logic [29:0] exp [3];
        exp[0] = {1'b1, 26'h01579A0, 1'b0, 1'b0, 1'b0};
        exp[1] = {1'b1, 26'h0624680, 1'b1, 1'b1, 1'b0};
        exp[2] = {1'b0, 26'h0624680, 1'b1, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        send(3'b100, 64'h1234_0000_0000_ABCD);
        for (int i = 0; i < 3; i++) begin
            got = {bus.out_valid, bus.out_imm26, bus.out_movk, bus.out_last, bus.out_err};
            n_checks++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL wide_skip_beat%0d: got %h required %h", i, got, exp[i]);
            end
            @(negedge CLK);
        end
        send(3'b111, 64'h0);
        got = {bus.out_valid, bus.out_imm26, bus.out_movk, bus.out_last, bus.out_err};
        n_checks++;
        if (got !== {1'b1, 26'h0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wide_zero: got %h required %h", got, {1'b1, 26'h0, 1'b0, 1'b1, 1'b0});
        end
        @(negedge CLK);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_zero_done: got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        logic [30:0] got, exp;
        exp = {1'b0, 1'b1, 26'h04AAAA0, 1'b0, 1'b1, 1'b0};
        bus.out_ready = 1'b0;
        send(3'b101, 64'h0000_5555_0000_0000);
        for (int i = 0; i < 3; i++) begin
            got = {bus.in_ready, bus.out_valid, bus.out_imm26, bus.out_movk, bus.out_last, bus.out_err};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h required %h", i, got, exp);
            end
            if (i < 2) @(negedge CLK);
        end
        bus.out_ready = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_release: got %b required %b", {bus.in_ready, bus.out_valid}, 2'b10);
        end
    endtask

    task automatic test_no_skip();
        logic [29:0] got;
        logic [29:0] exp [4];
        exp[0] = {1'b1, 26'h01579A0, 1'b0, 1'b0, 1'b0};
        exp[1] = {1'b1, 26'h0200000, 1'b1, 1'b0, 1'b0};
        exp[2] = {1'b1, 26'h0400000, 1'b1, 1'b0, 1'b0};
        exp[3] = {1'b1, 26'h0624680, 1'b1, 1'b1, 1'b0};
        bus_ns.out_ready = 1'b1;
        send_ns(3'b110, 64'h1234_0000_0000_ABCD);
        for (int i = 0; i < 4; i++) begin
            got = {bus_ns.out_valid, bus_ns.out_imm26, bus_ns.out_movk, bus_ns.out_last, bus_ns.out_err};
            n_checks++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL no_skip_beat%0d: got %h required %h", i, got, exp[i]);
            end
            @(negedge CLK);
        end
        n_checks++;
        if ({bus_ns.in_ready, bus_ns.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL no_skip_done: got %b required %b", {bus_ns.in_ready, bus_ns.out_valid}, 2'b10);
        end
    endtask

    task automatic test_reset_mid();
        logic [29:0] got, exp;
        exp = {1'b1, 26'h0000020, 1'b0, 1'b0, 1'b0};
        bus_ns.out_ready = 1'b1;
        send_ns(3'b100, 64'h0004_0003_0002_0001);
        got = {bus_ns.out_valid, bus_ns.out_imm26, bus_ns.out_movk, bus_ns.out_last, bus_ns.out_err};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rst_mid_beat0: got %h required %h", got, exp);
        end
        @(posedge CLK);
        #2;
        Reset_L = 1'b0;
        #1;
        n_checks++;
        if (bus_ns.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %b required 0", bus_ns.out_valid);
        end
        @(negedge CLK);
        Reset_L = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({bus_ns.in_ready, bus_ns.out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL rst_mid_idle%0d: got %b required %b", i, {bus_ns.in_ready, bus_ns.out_valid}, 2'b10);
            end
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_ctrl      = '0;
        bus.in_value     = '0;
        bus.out_ready    = 1'b1;
        bus_ns.in_valid  = 1'b0;
        bus_ns.in_ctrl   = '0;
        bus_ns.in_value  = '0;
        bus_ns.out_ready = 1'b1;
        test_reset();
        test_single();
        test_wide_skip();
        test_stall();
        test_no_skip();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
